lane_writeback_unit: RTL and testbench

- Write side of the per-lane register files: gathers per-lane results from the ALU or from memory load responses and drives the write port of every lane's register file in a single UPDATE cycle.
- Sits between the execute and memory stages and the 16 lane register files.
- Owns the write-enable, destination register and write data that each register file samples during UPDATE.

---
 rtl/lane_writeback_unit.sv | 213 +++++++++++++++++++++
 tb/tb_lane_writeback_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_writeback_unit.sv
// lane_writeback_unit
// Write side of the per-lane register files. One instruction at a time it
// collects per-lane results, either as one ALU vector or as individual
// memory load responses. It then drives every lane's register-file write
// port for a single WRITE (UPDATE) cycle and pulses done.
// All outputs are decoded from registered state, so no input reaches an
// output combinationally.

module lane_writeback_unit #(
    parameter int DATA_WIDTH     = 64,
    parameter int LANE_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 7,
    parameter int FIRST_RO_REG   = 28
) (
    input  logic                             clk,
    input  logic                             rst,

    // instruction configuration, latched on start
    input  logic                             start,
    input  logic [REG_ADDR_WIDTH-1:0]        cfg_rd,
    input  logic                             cfg_reg_write,
    input  logic                             cfg_mem_read,
    input  logic [LANE_WIDTH-1:0]            cfg_lane_mask,

    // ALU result vector
    input  logic                             alu_valid,
    input  logic [LANE_WIDTH*DATA_WIDTH-1:0] alu_result,

    // memory load responses, one lane per beat
    input  logic                             mem_rsp_valid,
    output logic                             mem_rsp_ready,
    input  logic [$clog2(LANE_WIDTH)-1:0]    mem_rsp_lane,
    input  logic [DATA_WIDTH-1:0]            mem_rsp_data,

    // status and register-file write port
    output logic                             busy,
    output logic [LANE_WIDTH-1:0]            wb_write_en,
    output logic [REG_ADDR_WIDTH-1:0]        wb_rd,
    output logic [LANE_WIDTH*DATA_WIDTH-1:0] wb_data,
    output logic                             done,
    output logic [1:0]                       err_sticky
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]                       state_q;
    logic [1:0]                       state_d;

    // latched instruction configuration
    logic [REG_ADDR_WIDTH-1:0]        rd_q;
    logic                             reg_write_q;
    logic                             mem_read_q;
    logic [LANE_WIDTH-1:0]            mask_q;

    // collection progress and per-lane capture buffer
    logic [LANE_WIDTH-1:0]            filled_q;
    logic [LANE_WIDTH*DATA_WIDTH-1:0] cap_q;
    logic [1:0]                       err_q;

    // decoded events for the current cycle
    logic                             start_accept;
    logic                             rd_is_ro;
    logic                             skip_write;
    logic                             in_collect;
    logic                             in_write;
    logic                             alu_capture;
    logic                             mem_accept;
    logic [LANE_WIDTH-1:0]            mem_lane_oh;
    logic                             mem_hit;
    logic                             mem_stray;

    assign in_collect   = (state_q == ST_COLLECT);
    assign in_write     = (state_q == ST_WRITE);
    assign start_accept = (state_q == ST_IDLE) && start;

    // Registers 28 and up are read-only; any rd at or above that bound is
    // never written.
    assign rd_is_ro   = (cfg_rd >= REG_ADDR_WIDTH'(FIRST_RO_REG));
    assign skip_write = !cfg_reg_write || (cfg_lane_mask == '0) || rd_is_ro;

    // alu_valid only counts once the instruction is in COLLECT, so a pulse
    // that coincides with start is ignored.
    assign alu_capture = in_collect && !mem_read_q && alu_valid;

    // In memory mode every presented response is accepted. Only a response
    // for an active lane that is not yet filled carries useful data.
    assign mem_accept  = in_collect && mem_read_q && mem_rsp_valid;
    assign mem_lane_oh = LANE_WIDTH'(1) << mem_rsp_lane;
    assign mem_hit     = mem_accept && ((mem_lane_oh & mask_q & ~filled_q) != '0);
    assign mem_stray   = mem_accept && !mem_hit;

    // Next-state selection for the writeback sequence.
    // NOTE: every always_comb output gets a default assignment first so that
    // no path through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = skip_write ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (!mem_read_q) begin
                    // ALU mode: the whole vector arrives in one beat.
                    if (alu_valid) begin
                        state_d = ST_WRITE;
                    end
                end else if (filled_q == mask_q) begin
                    // Memory mode: leave only once the registered filled
                    // mask covers every active lane.
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register; reset returns to IDLE at once, abandoning any collection.
    // NOTE: sequential state is always assigned with non-blocking (<=) so that
    // every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the instruction configuration on an accepted start only.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mask_q      <= '0;
        end else if (start_accept) begin
            rd_q        <= cfg_rd;
            reg_write_q <= cfg_reg_write;
            mem_read_q  <= cfg_mem_read;
            mask_q      <= cfg_lane_mask;
        end
    end

    // Track which active lanes already hold their result for this instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            filled_q <= '0;
        end else if (start_accept) begin
            filled_q <= '0;
        end else if (alu_capture) begin
            filled_q <= mask_q;
        end else if (mem_hit) begin
            filled_q <= filled_q | mem_lane_oh;
        end
    end

    // Capture per-lane results: whole masked vector from the ALU, or a single
    // lane from a first memory response to that lane.
    // NOTE: the capture buffer is plain flops, not a RAM, so it is reset with
    // everything else and comes up zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q <= '0;
        end else begin
            for (int i = 0; i < LANE_WIDTH; i++) begin
                if (alu_capture && mask_q[i]) begin
                    cap_q[i*DATA_WIDTH +: DATA_WIDTH] <= alu_result[i*DATA_WIDTH +: DATA_WIDTH];
                end else if (mem_hit && mem_lane_oh[i]) begin
                    cap_q[i*DATA_WIDTH +: DATA_WIDTH] <= mem_rsp_data;
                end
            end
        end
    end

    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 2'b00;
        end else begin
            if (start_accept && cfg_reg_write && rd_is_ro) begin
                err_q[1] <= 1'b1;
            end
            if (mem_stray) begin
                err_q[0] <= 1'b1;
            end
        end
    end

    // Output decode: everything below depends only on registered state.
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign mem_rsp_ready = in_collect && mem_read_q;
    assign err_sticky    = err_q;
    assign wb_write_en   = (in_write && reg_write_q) ? mask_q : '0;
    assign wb_rd         = in_write ? rd_q : '0;

    // Write data is driven only during WRITE, and only for active lanes.
    always_comb begin
        wb_data = '0;
        for (int i = 0; i < LANE_WIDTH; i++) begin
            if (in_write && mask_q[i]) begin
                wb_data[i*DATA_WIDTH +: DATA_WIDTH] = cap_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_lane_writeback_unit.sv
// Self-checking bench for lane_writeback_unit.
// A transaction-level reference model predicts, for each instruction, the
// WRITE and done cycles, the lanes written with their data, the cycles in
// which responses are accepted, and the sticky errors.

module tb_lane_writeback_unit;

    localparam int DW  = 64;
    localparam int LW  = 16;
    localparam int AW  = 7;
    localparam int RO  = 28;
    localparam int VW  = LW * DW;

    logic            clk;
    logic            rst;
    logic            start;
    logic [AW-1:0]   cfg_rd;
    logic            cfg_reg_write;
    logic            cfg_mem_read;
    logic [LW-1:0]   cfg_lane_mask;
    logic            alu_valid;
    logic [VW-1:0]   alu_result;
    logic            mem_rsp_valid;
    logic            mem_rsp_ready;
    logic [3:0]      mem_rsp_lane;
    logic [DW-1:0]   mem_rsp_data;
    logic            busy;
    logic [LW-1:0]   wb_write_en;
    logic [AW-1:0]   wb_rd;
    logic [VW-1:0]   wb_data;
    logic            done;
    logic [1:0]      err_sticky;

    lane_writeback_unit #(
        .DATA_WIDTH    (DW),
        .LANE_WIDTH    (LW),
        .REG_ADDR_WIDTH(AW),
        .FIRST_RO_REG  (RO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_rd       (cfg_rd),
        .cfg_reg_write(cfg_reg_write),
        .cfg_mem_read (cfg_mem_read),
        .cfg_lane_mask(cfg_lane_mask),
        .alu_valid    (alu_valid),
        .alu_result   (alu_result),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_lane (mem_rsp_lane),
        .mem_rsp_data (mem_rsp_data),
        .busy         (busy),
        .wb_write_en  (wb_write_en),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .done         (done),
        .err_sticky   (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            t;
        logic [3:0]    lane;
        logic [DW-1:0] data;
    } rsp_t;

    int            compared   = 0;
    int            mismatched = 0;
    rsp_t          plan[$];
    logic [DW-1:0] exp_data[LW];
    logic [1:0]    exp_err;

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] pack_exp();
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < LW; i++) v[i*DW +: DW] = exp_data[i];
        return v;
    endfunction

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic drive_idle_junk();
        start         = 1'b0;
        alu_valid     = 1'b0;
        mem_rsp_valid = 1'b0;
        cfg_rd        = AW'($urandom);
        cfg_reg_write = 1'($urandom);
        cfg_mem_read  = 1'($urandom);
        cfg_lane_mask = LW'($urandom);
        mem_rsp_lane  = 4'($urandom);
        mem_rsp_data  = rnd64();
        for (int i = 0; i < LW; i++) alu_result[i*DW +: DW] = rnd64();
    endtask

    task automatic check_all(input string ph, input logic exp_busy, input logic exp_done,
                             input logic [LW-1:0] exp_en, input logic [AW-1:0] exp_rd,
                             input logic [VW-1:0] exp_vec, input logic exp_rdy);
        check({ph, ".busy"},  busy,          exp_busy);
        check({ph, ".done"},  done,          exp_done);
        check({ph, ".en"},    wb_write_en,   exp_en);
        check({ph, ".rd"},    wb_rd,         exp_rd);
        check({ph, ".data"},  wb_data,       exp_vec);
        check({ph, ".ready"}, mem_rsp_ready, exp_rdy);
        check({ph, ".err"},   err_sticky,    exp_err);
    endtask

    // One instruction from start until back in IDLE, checked every cycle.
    // Cycle 0 is the start cycle. In ALU mode WRITE is one cycle after
    // alu_valid. In memory mode WRITE is two cycles after the response that
    // completes the mask, since the cycle in between still accepts responses.
    task automatic run_instr(input string tag, input logic [AW-1:0] rd, input logic rw,
                             input logic mr, input logic [LW-1:0] mask,
                             input bit alu_dir, input int ta, input bit restart);
        logic [LW-1:0] filled;
        int            w, d, tf, c, r;
        bit            early, rdy, drv;
        logic [3:0]    lane;
        logic [DW-1:0] data;
        int            cand[$];
        for (int i = 0; i < LW; i++) exp_data[i] = '0;
        filled = '0;
        tf     = -1;
        early  = !rw || (mask == '0) || (rd >= AW'(RO));
        if (early) begin
            w = -1; d = 1;
        end else if (!mr) begin
            w = ta + 1; d = ta + 2;
        end else begin
            w = -1; d = -1;
        end
        c = 0;
        while ((d < 0 || c <= d + 1) && c < 300) begin
            rdy = mr && !early && c >= 1 && (tf < 0 || c <= tf + 1);
            check_all(tag, c >= 1 && (d < 0 || c <= d), c == d,
                      (c == w) ? mask : '0, (c == w) ? rd : '0,
                      (c == w) ? pack_exp() : '0, rdy);
            drive_idle_junk();
            if (c == 0) begin
                start         = 1'b1;
                cfg_rd        = rd;
                cfg_reg_write = rw;
                cfg_mem_read  = mr;
                cfg_lane_mask = mask;
                // Decoys in the start cycle must be ignored.
                alu_valid     = 1'($urandom);
                mem_rsp_valid = 1'($urandom);
                if (rw && rd >= AW'(RO)) exp_err[1] = 1'b1;
            end
            if (c == 1 && restart) start = 1'b1;
            if (!mr && !early && c == ta) begin
                alu_valid = 1'b1;
                for (int i = 0; i < LW; i++) begin
                    if (alu_dir) alu_result[i*DW +: DW] = DW'(i + 100);
                    if (mask[i]) exp_data[i] = alu_result[i*DW +: DW];
                end
            end
            if (!mr && c >= 1) mem_rsp_valid = ($urandom_range(0, 3) == 0);
            if (mr && c >= 1) begin
                drv  = 1'b0;
                lane = 4'($urandom);
                data = rnd64();
                if (plan.size() > 0) begin
                    foreach (plan[k]) begin
                        if (plan[k].t == c) begin
                            drv = 1'b1; lane = plan[k].lane; data = plan[k].data;
                        end
                    end
                end else if (rdy) begin
                    r = $urandom_range(0, 7);
                    if (r >= 2) begin
                        drv = 1'b1;
                        if (r != 2) begin
                            cand.delete();
                            for (int i = 0; i < LW; i++)
                                if (mask[i] && !filled[i]) cand.push_back(i);
                            if (cand.size() > 0)
                                lane = 4'(cand[$urandom_range(0, cand.size() - 1)]);
                        end
                    end
                end else begin
                    drv = ($urandom_range(0, 3) == 0);
                end
                if (drv) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_lane  = lane;
                    mem_rsp_data  = data;
                    if (rdy) begin
                        if (mask[lane] && !filled[lane]) begin
                            exp_data[lane] = data;
                            filled[lane]   = 1'b1;
                        end else begin
                            exp_err[0] = 1'b1;
                        end
                        if (filled == mask && tf < 0) begin
                            tf = c; w = c + 2; d = c + 3;
                        end
                    end
                end
            end
            if (d >= 0 && c >= d + 1) break;
            tick();
            c++;
        end
        check({tag, ".bound"}, d >= 0, 1'b1);
        start = 1'b0; alu_valid = 1'b0; mem_rsp_valid = 1'b0;
        plan.delete();
    endtask

    function automatic rsp_t mk(input int t, input logic [3:0] lane, input logic [DW-1:0] data);
        rsp_t s;
        s.t = t; s.lane = lane; s.data = data;
        return s;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] rrd;
        logic [LW-1:0] rmask;
        rst = 1'b1;
        drive_idle_junk();
        exp_err = 2'b00;
        tick();
        tick();
        check_all("reset", 1'b0, 1'b0, '0, '0, '0, 1'b0);
        rst = 1'b0;
        tick();

        // ALU path, all lanes, lane i = i+100; start pulse while busy ignored
        run_instr("alu_full", 7'd5, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1, 1'b1);

        // Memory path, lanes 0 and 2, responses on consecutive cycles
        plan.push_back(mk(1, 4'd2, 64'hAA));
        plan.push_back(mk(2, 4'd0, 64'hBB));
        run_instr("mem_two", 7'd9, 1'b1, 1'b1, 16'h0005, 1'b0, 1, 1'b0);

        // No-write cases without error
        run_instr("no_regwr", 7'd5, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1, 1'b0);
        run_instr("mask_zero", 7'd5, 1'b1, 1'b1, 16'h0000, 1'b0, 1, 1'b0);

        // Stray lane 3 then lane 0 twice; the first lane-0 data is written
        plan.push_back(mk(1, 4'd3, 64'h3333));
        plan.push_back(mk(2, 4'd0, 64'h1111_0000));
        plan.push_back(mk(3, 4'd0, 64'h2222_0000));
        run_instr("mem_dup", 7'd12, 1'b1, 1'b1, 16'h0001, 1'b0, 1, 1'b0);

        // Read-only destination
        run_instr("ro_rd", 7'd29, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1, 1'b0);
        run_instr("ro_bound", 7'd28, 1'b1, 1'b1, 16'h00F0, 1'b0, 1, 1'b0);
        run_instr("rw_bound", 7'd27, 1'b1, 1'b0, 16'h8001, 1'b0, 2, 1'b0);

        // Reset in COLLECT after one of two responses
        drive_idle_junk();
        start = 1'b1; cfg_rd = 7'd7; cfg_reg_write = 1'b1;
        cfg_mem_read = 1'b1; cfg_lane_mask = 16'h0003;
        tick();
        check("rstmid.ready1", mem_rsp_ready, 1'b1);
        drive_idle_junk();
        mem_rsp_valid = 1'b1; mem_rsp_lane = 4'd0; mem_rsp_data = 64'h55;
        tick();
        check("rstmid.busy2", busy, 1'b1);
        check("rstmid.en2", wb_write_en, '0);
        drive_idle_junk();
        rst = 1'b1;
        mem_rsp_valid = 1'b1; mem_rsp_lane = 4'd1; mem_rsp_data = 64'h66;
        tick();
        rst = 1'b0;
        exp_err = 2'b00;
        check_all("rstmid.after", 1'b0, 1'b0, '0, '0, '0, 1'b0);
        drive_idle_junk();
        mem_rsp_valid = 1'b1; mem_rsp_lane = 4'd1; mem_rsp_data = 64'h66;
        tick();
        check_all("rstmid.late", 1'b0, 1'b0, '0, '0, '0, 1'b0);
        mem_rsp_valid = 1'b0;
        run_instr("rstmid.rerun", 7'd7, 1'b1, 1'b1, 16'h0003, 1'b0, 1, 1'b0);

        // Randomized instructions
        for (int n = 0; n < 40; n++) begin
            rrd   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, RO - 1));
            case ($urandom_range(0, 7))
                0:       rmask = 16'h0000;
                1:       rmask = 16'hFFFF;
                default: rmask = LW'($urandom);
            endcase
            run_instr("rand", rrd, ($urandom_range(0, 7) != 0), 1'($urandom), rmask,
                      1'b0, $urandom_range(1, 3), ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
